// File: rtl/common_dffram_3a2w1r.sv
// Flip-flop RAM with two write ports (A, B) and one registered read port (C).
// B wins over A when both write the same entry; a collision is flagged one cycle later.
module common_dffram_3a2w1r #(
  parameter int RAM_DATA_WIDTH = 1,
  parameter int RAM_ADDR_WIDTH = 1,
  parameter logic [(2**RAM_ADDR_WIDTH)*RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0,
  parameter bit READ_BYPASS = 1'b0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [RAM_ADDR_WIDTH-1:0] addra,
  input  logic                      ena,
  input  logic                      wea,
  input  logic [RAM_DATA_WIDTH-1:0] dina,
  input  logic [RAM_ADDR_WIDTH-1:0] addrb,
  input  logic                      enb,
  input  logic                      web,
  input  logic [RAM_DATA_WIDTH-1:0] dinb,
  input  logic [RAM_ADDR_WIDTH-1:0] addrc,
  input  logic                      enc,
  output logic [RAM_DATA_WIDTH-1:0] doutc,
  output logic                      collab
);

  localparam int DEPTH = 2**RAM_ADDR_WIDTH;

  logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];
  logic                      wa;
  logic                      wb;
  logic                      coll_p0;
  logic [RAM_DATA_WIDTH-1:0] rd_data_p0;

  assign wa      = ena & wea;
  assign wb      = enb & web;
  assign coll_p0 = wa & wb & (addra == addrb);

  // Per-entry storage; port B is checked first so it overrides A on a shared address.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        mem[g] <= RAM_RESET_VALUE[g*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
      end else if (wb && (addrb == RAM_ADDR_WIDTH'(g))) begin
        mem[g] <= dinb;
      end else if (wa && (addra == RAM_ADDR_WIDTH'(g))) begin
        mem[g] <= dina;
      end
    end
  end

  always_comb begin
    rd_data_p0 = mem[addrc];
    if (READ_BYPASS) begin
      if (wb && (addrb == addrc)) begin
        rd_data_p0 = dinb;
      end else if (wa && (addra == addrc)) begin
        rd_data_p0 = dina;
      end
    end
  end

  // Stage p0 -> p1: registered read data and collision flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      doutc  <= '0;
      collab <= 1'b0;
    end else begin
      collab <= coll_p0;
      if (enc) begin
        doutc <= rd_data_p0;
      end
    end
  end

endmodule
